// File: rtl/sync_ram_bist_if.sv
// Port bundle between the BIST engine and one single-port sync_ram instance.
interface sync_ram_bist_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (output ram_we, output ram_addr, output ram_din, input ram_dout);
  modport slave  (input ram_we, input ram_addr, input ram_din, output ram_dout);
endinterface

// File: rtl/sync_ram_bist.sv
// March C- self-test engine for a single-port sync_ram (1-cycle read latency).
// Runs zeros/ones backgrounds on a start pulse and reports the first mismatch.
module sync_ram_bist #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            fail_elem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  sync_ram_bist_if.master       ram
);

  localparam logic [2:0]            LAST_ELEM = 3'd5;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Element table: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0)
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_has_rd(input logic [2:0] e);
    return e != 3'd0;
  endfunction

  function automatic logic elem_has_wr(input logic [2:0] e);
    return e != LAST_ELEM;
  endfunction

  function automatic logic elem_rd_one(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic elem_wr_one(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;

  logic                  cmp_vld_q, cmp_vld_d;
  logic                  cmp_one_q, cmp_one_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]            cmp_elem_q, cmp_elem_d;

  logic                  busy_d, done_d, pass_d;
  logic [2:0]            fail_elem_d;
  logic [ADDR_WIDTH-1:0] fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_d;
  logic                  ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_d;

  logic                  at_end_c, last_op_c, mismatch_c, cur_rd_c;
  logic [2:0]            adv_elem;
  logic [ADDR_WIDTH-1:0] adv_addr;
  logic                  adv_phase;
  logic                  issue;
  logic [2:0]            op_elem;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic                  op_phase;

  // The down counter stops at address 0 instead of wrapping.
  assign at_end_c   = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign last_op_c  = (elem_q == LAST_ELEM) && at_end_c;
  assign cur_rd_c   = elem_has_rd(elem_q) && !phase_q;
  assign mismatch_c = cmp_vld_q && (ram.ram_dout != {DATA_WIDTH{cmp_one_q}});

  // Sequence position of the op following the one currently on the RAM port.
  always_comb begin
    adv_elem  = elem_q;
    adv_addr  = addr_q;
    adv_phase = 1'b0;
    if (elem_has_rd(elem_q) && elem_has_wr(elem_q) && !phase_q) begin
      adv_phase = 1'b1;
    end else if (at_end_c) begin
      adv_elem = 3'(elem_q + 3'd1);
      adv_addr = elem_down(3'(elem_q + 3'd1)) ? ADDR_MAX : '0;
    end else if (elem_down(elem_q)) begin
      adv_addr = addr_q - ADDR_WIDTH'(1);
    end else begin
      adv_addr = addr_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    busy_d      = busy;
    done_d      = done;
    pass_d      = pass;
    fail_elem_d = fail_elem;
    fail_addr_d = fail_addr;
    fail_data_d = fail_data;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram.ram_addr;
    ram_din_d   = ram.ram_din;
    // A read on the port this cycle is compared when its data returns next cycle.
    cmp_vld_d   = (state_q == S_RUN) && cur_rd_c;
    cmp_one_d   = elem_rd_one(elem_q);
    cmp_addr_d  = addr_q;
    cmp_elem_d  = elem_q;
    issue       = 1'b0;
    op_elem     = adv_elem;
    op_addr     = adv_addr;
    op_phase    = adv_phase;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_elem_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          issue       = 1'b1;
          op_elem     = '0;
          op_addr     = '0;
          op_phase    = 1'b0;
        end
      end
      S_RUN: begin
        if (mismatch_c) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          fail_elem_d = cmp_elem_q;
          fail_addr_d = cmp_addr_q;
          fail_data_d = ram.ram_dout;
        end else if (last_op_c) begin
          state_d = S_DRAIN;
        end else begin
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = !mismatch_c;
        if (mismatch_c) begin
          fail_elem_d = cmp_elem_q;
          fail_addr_d = cmp_addr_q;
          fail_data_d = ram.ram_dout;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      elem_d     = op_elem;
      addr_d     = op_addr;
      phase_d    = op_phase;
      ram_addr_d = op_addr;
      if (!(elem_has_rd(op_elem) && !op_phase)) begin
        ram_we_d  = 1'b1;
        ram_din_d = {DATA_WIDTH{elem_wr_one(op_elem)}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      elem_q       <= '0;
      addr_q       <= '0;
      phase_q      <= 1'b0;
      cmp_vld_q    <= 1'b0;
      cmp_one_q    <= 1'b0;
      cmp_addr_q   <= '0;
      cmp_elem_q   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_elem    <= '0;
      fail_addr    <= '0;
      fail_data    <= '0;
      ram.ram_we   <= 1'b0;
      ram.ram_addr <= '0;
      ram.ram_din  <= '0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_one_q    <= cmp_one_d;
      cmp_addr_q   <= cmp_addr_d;
      cmp_elem_q   <= cmp_elem_d;
      busy         <= busy_d;
      done         <= done_d;
      pass         <= pass_d;
      fail_elem    <= fail_elem_d;
      fail_addr    <= fail_addr_d;
      fail_data    <= fail_data_d;
      ram.ram_we   <= ram_we_d;
      ram.ram_addr <= ram_addr_d;
      ram.ram_din  <= ram_din_d;
    end
  end

endmodule
